conv_pool_bridge: RTL and testbench
===================================

// Module: conv_pool_bridge
// PURPOSE
// - Joins a conv_layer to the pool_layer that follows it.
// - The conv stage emits one channel value per cycle on its serial o_func_data.
//   This block collects those values into a full per-pixel channel vector.
// - It then writes the vector into the pool stage's per-channel input buffers in one cycle.
// - After the last pixel of a frame it pulses the pool stage's i_start.
// - Upstream is stalled with o_busy; downstream backpressure arrives on i_next_busy.
// PARAMETERS
// - datatype_size   8    bit width of one activation
// - channels        6    conv output channels = pool input channels
// - img_width       24   conv output image width; one frame = img_width**2 pixels
// PORTS
// - clk              in   1              single clock, rising edge
// - rst              in   1              synchronous, active-high reset
// - i_valid          in   1              i_data carries one channel value this cycle
// - i_data           in   datatype_size  serial channel value from conv o_func_data
// - o_busy           out  1              bridge cannot accept; upstream holds i_valid/i_data
// - i_next_busy      in   1              pool stage cannot take writes or start
// - o_ibuf_we        out  1 [channels]   per-channel write enable to pool i_ibuf_we
// - o_ibuf_wr_data   out  datatype_size [channels]  per-channel data to pool i_ibuf_wr_data
// - o_start          out  1              one-cycle frame start pulse to pool i_start
// BEHAVIOUR
// - Reset values: o_ibuf_we all 0, o_ibuf_wr_data all 0, o_start 0, o_busy 0.
// - Reset also clears ch_cnt and pix_cnt and returns the FSM to COLLECT.
// - Reset mid-frame discards any partial vector and any partial frame.
// - Counters:
//   - ch_cnt is [max(1,$clog2(channels))-1:0] and counts 0..channels-1.
//   - pix_cnt is [$clog2(img_width**2)-1:0] and counts 0..img_width**2-1.
// - o_busy = (state != COLLECT). It is a decode of the registered state only; no input-to-output path.
// - COLLECT state:
//   - A value is accepted when i_valid=1 and o_busy=0.
//   - The accepted value goes to vec[ch_cnt], then ch_cnt increments.
//   - When ch_cnt==channels-1 is accepted: ch_cnt wraps to 0 and the FSM moves to WRITE.
//   - For channels=1 every accepted value moves the FSM to WRITE.
// - WRITE state:
//   - While i_next_busy=1: o_ibuf_we stays 0 and the state holds.
//   - Once i_next_busy=0, for exactly one cycle: o_ibuf_we all 1 and o_ibuf_wr_data = vec.
//   - pix_cnt then increments.
//   - If pix_cnt was img_width**2-1: pix_cnt wraps to 0 and the FSM moves to START.
//   - Otherwise the FSM returns to COLLECT.
// - START state:
//   - Waits for i_next_busy=0, then drives o_start=1 for one cycle and returns to COLLECT.
// - Output timing:
//   - o_ibuf_we and o_start are registered and are 0 in every cycle not listed above.
//   - o_ibuf_wr_data holds its last written vector between writes.
// - Latency:
//   - Last channel accepted on cycle N -> o_ibuf_we on cycle N+1 when i_next_busy=0.
//   - Last pixel's write on cycle M -> o_start on cycle M+1 at the earliest.
// - Throughput: at most one pixel per channels+1 cycles.
//   - i_valid asserted while o_busy=1 is ignored; no data is lost because upstream holds.
// - i_next_busy changing while in COLLECT has no effect; it is sampled only in WRITE/START.
// STRUCTURE
// - Shared package cim_pkg:
//   - typedef logic [datatype_size-1:0] act_t
//   - enum bridge_state_t {COLLECT, WRITE, START}
// - Single module. Vector register, two counters and a 3-state FSM. No sub-module.
// TESTING
// (bench parameters: channels=6, img_width=2, i.e. 4 pixels per frame)
// - Reset then idle: rst=1 for 2 cycles -> all outputs 0, o_busy=0.
// - One pixel: send 6 values 0x10..0x15 back-to-back.
//   -> next cycle o_ibuf_we=6'b111111, wr_data[0..5]=0x10..0x15, o_busy=1 for exactly 1 cycle.
// - Downstream stall: same as above but i_next_busy=1 for 5 cycles after the 6th value.
//   -> o_ibuf_we stays 0 and o_busy=1 for 5 cycles; write happens the cycle i_next_busy drops.
// - Frame end: 4 pixels (24 values) with i_next_busy=0.
//   -> 4 write pulses, then o_start=1 one cycle after the 4th write, pix_cnt back to 0.
//   - Hold i_next_busy=1 at START -> o_start delayed until it drops.
// - Upstream held during busy: i_valid=1 with value 0xAA during the WRITE cycle.
//   -> 0xAA not captured; captured as channel 0 the next cycle.
// - Reset mid-operation: rst after 3 of 6 values.
//   -> next full 6 values form a clean vector; no stale values and no spurious o_ibuf_we.

Source files
------------

// File: rtl/cim_pkg.sv
// rtl/cim_pkg.sv - shared types for the conv/pool compute-in-memory pipeline
//
// Purpose: common activation type and bridge FSM state encoding.
// Ports:   none (package).

package cim_pkg;

  localparam int DATATYPE_SIZE = 8;

  typedef logic [DATATYPE_SIZE-1:0] act_t;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    WRITE   = 2'd1,
    START   = 2'd2
  } bridge_state_t;

endpackage

// File: rtl/conv_pool_bridge.sv
// rtl/conv_pool_bridge.sv - serial conv output to parallel pool input buffer bridge
//
// Purpose: gathers one channel value per accepted cycle into a per-pixel channel
//          vector, writes the whole vector into the pool stage's per-channel input
//          buffers in a single cycle, and pulses the pool start after the last
//          pixel of a frame.
// Ports:
//   clk            in   clock, rising edge
//   rst            in   synchronous active-high reset
//   i_valid        in   i_data carries one channel value
//   i_data         in   serial channel value from the conv stage
//   o_busy         out  bridge cannot accept; upstream holds its data
//   i_next_busy    in   pool stage cannot take writes or start
//   o_ibuf_we      out  per-channel write enables to the pool input buffers
//   o_ibuf_wr_data out  per-channel write data to the pool input buffers
//   o_start        out  one-cycle frame start pulse to the pool stage

module conv_pool_bridge
  import cim_pkg::*;
#(
  parameter int datatype_size = DATATYPE_SIZE,
  parameter int channels      = 6,
  parameter int img_width     = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  input  logic [datatype_size-1:0] i_data,
  output logic                     o_busy,
  input  logic                     i_next_busy,
  output logic [channels-1:0]      o_ibuf_we,
  output logic [datatype_size-1:0] o_ibuf_wr_data [channels],
  output logic                     o_start
);

  localparam int NUM_PIX = img_width * img_width;
  localparam int CH_W    = (channels > 1) ? $clog2(channels) : 1;
  localparam int PIX_W   = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;

  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(channels - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NUM_PIX - 1);

  bridge_state_t state_q, state_d;
  logic [CH_W-1:0]          ch_cnt_q, ch_cnt_d;
  logic [PIX_W-1:0]         pix_cnt_q, pix_cnt_d;
  logic [datatype_size-1:0] vec_q [channels];
  logic [datatype_size-1:0] vec_d [channels];
  logic [channels-1:0]      we_q, we_d;
  logic [datatype_size-1:0] wr_data_q [channels];
  logic [datatype_size-1:0] wr_data_d [channels];
  logic                     start_q, start_d;

  always_comb begin
    state_d   = state_q;
    ch_cnt_d  = ch_cnt_q;
    pix_cnt_d = pix_cnt_q;
    vec_d     = vec_q;
    wr_data_d = wr_data_q;
    we_d      = '0;
    start_d   = 1'b0;

    unique case (state_q)
      COLLECT: begin
        // i_next_busy is deliberately ignored here; it only gates WRITE/START.
        if (i_valid) begin
          vec_d[ch_cnt_q] = i_data;
          if (ch_cnt_q == CH_LAST) begin
            ch_cnt_d = '0;
            state_d  = WRITE;
          end else begin
            ch_cnt_d = ch_cnt_q + CH_W'(1);
          end
        end
      end
      WRITE: begin
        if (!i_next_busy) begin
          we_d      = '1;
          wr_data_d = vec_q;
          if (pix_cnt_q == PIX_LAST) begin
            pix_cnt_d = '0;
            state_d   = START;
          end else begin
            pix_cnt_d = pix_cnt_q + PIX_W'(1);
            state_d   = COLLECT;
          end
        end
      end
      START: begin
        if (!i_next_busy) begin
          start_d = 1'b1;
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= COLLECT;
      ch_cnt_q  <= '0;
      pix_cnt_q <= '0;
      vec_q     <= '{default: '0};
      we_q      <= '0;
      wr_data_q <= '{default: '0};
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_cnt_q  <= ch_cnt_d;
      pix_cnt_q <= pix_cnt_d;
      vec_q     <= vec_d;
      we_q      <= we_d;
      wr_data_q <= wr_data_d;
      start_q   <= start_d;
    end
  end

  // Pure state decode so upstream never sees a combinational path from inputs.
  assign o_busy         = (state_q != COLLECT);
  assign o_ibuf_we      = we_q;
  assign o_ibuf_wr_data = wr_data_q;
  assign o_start        = start_q;

endmodule

// File: tb/tb_conv_pool_bridge.sv
// tb/tb_conv_pool_bridge.sv - self-checking bench for conv_pool_bridge

module tb_conv_pool_bridge;

  localparam int DW  = 8;
  localparam int CH  = 6;
  localparam int IW  = 2;
  localparam int PIX = IW * IW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          o_busy;
  logic          i_next_busy = 1'b0;
  logic [CH-1:0] o_ibuf_we;
  logic [DW-1:0] o_ibuf_wr_data [CH];
  logic          o_start;

  int total = 0;
  int bad   = 0;

  conv_pool_bridge #(
    .datatype_size(DW),
    .channels     (CH),
    .img_width    (IW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_valid       (i_valid),
    .i_data        (i_data),
    .o_busy        (o_busy),
    .i_next_busy   (i_next_busy),
    .o_ibuf_we     (o_ibuf_we),
    .o_ibuf_wr_data(o_ibuf_wr_data),
    .o_start       (o_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CH*DW-1:0] pack_dut();
    logic [CH*DW-1:0] r;
    for (int c = 0; c < CH; c++) r[c*DW +: DW] = o_ibuf_wr_data[c];
    return r;
  endfunction

  // Reference model: a queue of values collected for the current pixel, a
  // flag for a complete vector awaiting its buffer write, a flag for a frame
  // awaiting its start pulse, and a count of pixels written in the frame.
  logic [DW-1:0]    cur_q [$];
  logic [DW-1:0]    held_vec [CH];
  logic [CH*DW-1:0] m_data = '0;
  bit               pend_vec = 0;
  bit               pend_start = 0;
  int               pix_done = 0;
  bit               m_we = 0;
  bit               m_start = 0;
  int               m_starts = 0;
  int               dut_starts = 0;

  always @(posedge clk) begin
    if (rst) begin
      cur_q.delete();
      pend_vec   = 0;
      pend_start = 0;
      pix_done   = 0;
      m_we       = 0;
      m_start    = 0;
      m_data     = '0;
    end else begin
      m_we    = 0;
      m_start = 0;
      if (pend_vec) begin
        if (!i_next_busy) begin
          m_we = 1;
          for (int c = 0; c < CH; c++) m_data[c*DW +: DW] = held_vec[c];
          pend_vec = 0;
          pix_done++;
          if (pix_done == PIX) begin
            pix_done   = 0;
            pend_start = 1;
          end
        end
      end else if (pend_start) begin
        if (!i_next_busy) begin
          m_start    = 1;
          pend_start = 0;
          m_starts++;
        end
      end else if (i_valid) begin
        cur_q.push_back(i_data);
        if (cur_q.size() == CH) begin
          for (int c = 0; c < CH; c++) held_vec[c] = cur_q[c];
          cur_q.delete();
          pend_vec = 1;
        end
      end
    end
    #1;
    if (o_start === 1'b1) dut_starts++;
    chk("busy", {63'd0, o_busy}, {63'd0, pend_vec | pend_start});
    chk("we", {58'd0, o_ibuf_we}, m_we ? 64'h3F : 64'h0);
    chk("wr_data", {16'd0, pack_dut()}, {16'd0, m_data});
    chk("start", {63'd0, o_start}, {63'd0, m_start});
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic send_pixel(input logic [DW-1:0] base);
    for (int c = 0; c < CH; c++) begin
      i_valid = 1'b1;
      i_data  = base + DW'(c);
      tick();
    end
    i_valid = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_we", {58'd0, o_ibuf_we}, 64'h0);
    chk("rst_busy", {63'd0, o_busy}, 64'h0);
    chk("rst_start", {63'd0, o_start}, 64'h0);
    chk("rst_data", {16'd0, pack_dut()}, 64'h0);

    // one pixel, no backpressure
    send_pixel(8'h10);
    chk("px_busy", {63'd0, o_busy}, 64'h1);
    chk("px_we_early", {58'd0, o_ibuf_we}, 64'h0);
    tick();
    chk("px_we", {58'd0, o_ibuf_we}, 64'h3F);
    chk("px_data", {16'd0, pack_dut()}, 64'h0000_1514_1312_1110);
    chk("px_busy_done", {63'd0, o_busy}, 64'h0);
    tick();
    chk("px_we_pulse", {58'd0, o_ibuf_we}, 64'h0);

    // downstream stall for 5 cycles
    send_pixel(8'h20);
    i_next_busy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_we", {58'd0, o_ibuf_we}, 64'h0);
      chk("stall_busy", {63'd0, o_busy}, 64'h1);
    end
    i_next_busy = 1'b0;
    tick();
    chk("stall_we_rel", {58'd0, o_ibuf_we}, 64'h3F);
    chk("stall_data", {16'd0, pack_dut()}, 64'h0000_2524_2322_2120);

    // full frame, start held off by downstream
    do_reset();
    for (int p = 0; p < PIX; p++) begin
      send_pixel(8'h40 + 8'(p * 8));
      tick();
      chk("frame_we", {58'd0, o_ibuf_we}, 64'h3F);
    end
    chk("frame_busy_start", {63'd0, o_busy}, 64'h1);
    i_next_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("start_held", {63'd0, o_start}, 64'h0);
    end
    i_next_busy = 1'b0;
    tick();
    chk("start_pulse", {63'd0, o_start}, 64'h1);
    tick();
    chk("start_once", {63'd0, o_start}, 64'h0);

    // upstream holds 0xAA across the WRITE cycle
    send_pixel(8'h60);
    i_valid = 1'b1;
    i_data  = 8'hAA;
    tick();
    tick();
    for (int c = 1; c < CH; c++) begin
      i_data = 8'hB0 + 8'(c);
      tick();
    end
    i_valid = 1'b0;
    tick();
    chk("hold_data", {16'd0, pack_dut()}, 64'h0000_B5B4_B3B2_B1AA);

    // reset after 3 of 6 values
    for (int c = 0; c < 3; c++) begin
      i_valid = 1'b1;
      i_data  = 8'hEE;
      tick();
    end
    do_reset();
    send_pixel(8'h30);
    tick();
    chk("rst_mid_data", {16'd0, pack_dut()}, 64'h0000_3534_3332_3130);

    // randomized traffic with occasional resets
    for (int n = 0; n < 4000; n++) begin
      rst         = ($urandom_range(0, 699) == 0);
      i_valid     = ($urandom_range(0, 9) < 7);
      i_data      = DW'($urandom);
      i_next_busy = ($urandom_range(0, 9) < 3);
      tick();
    end
    rst = 1'b0;
    i_valid = 1'b0;
    i_next_busy = 1'b0;
    tick();
    tick();
    chk("start_count", 64'(dut_starts), 64'(m_starts));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
